// File: rtl/matrix_op_sched.sv
// Command scheduler for matrix_alu: validates opcodes, runs the start/done/error
// handshake with a timeout watchdog, reports status and arbitrates the memory read port.
module matrix_op_sched #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_opcode_i,
  input  logic [15:0] cmd_scalar_i,
  output logic        alu_start_o,
  output logic [2:0]  alu_opcode_o,
  output logic [15:0] alu_scalar_o,
  input  logic        alu_done_i,
  input  logic        alu_error_i,
  output logic        result_valid_o,
  output logic [1:0]  result_status_o,
  output logic [15:0] last_cycles_o,
  output logic        busy_o,
  input  logic        disp_req_i,
  output logic        disp_gnt_o,
  input  logic [1:0]  disp_rd_slot_i,
  input  logic [2:0]  disp_rd_row_i,
  input  logic [2:0]  disp_rd_col_i,
  input  logic [1:0]  alu_rd_slot_i,
  input  logic [2:0]  alu_rd_row_i,
  input  logic [2:0]  alu_rd_col_i,
  output logic [1:0]  mem_rd_slot_o,
  output logic [2:0]  mem_rd_row_o,
  output logic [2:0]  mem_rd_col_o
);

  typedef enum logic [2:0] {IDLE, RUN, RELEASE, REPORT, FAULT} state_e;

  localparam logic [1:0]  ST_OK      = 2'b00;
  localparam logic [1:0]  ST_DIM_ERR = 2'b01;
  localparam logic [1:0]  ST_BAD_OP  = 2'b10;
  localparam logic [1:0]  ST_TIMEOUT = 2'b11;
  localparam logic [31:0] CNT_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        start_q, start_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [15:0] scalar_q, scalar_d;
  logic        valid_q, valid_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] last_q, last_d;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  pendStatus_q, pendStatus_d;
  logic [15:0] pendCycles_q, pendCycles_d;
  logic        faultNext_q, faultNext_d;

  logic [31:0] cntInc;
  logic [15:0] cyclesSat;

  // cnt_q+1 is the number of cycles alu_start has been high, including this one.
  assign cntInc    = cnt_q + 32'd1;
  assign cyclesSat = (cntInc > 32'h0000_FFFF) ? 16'hFFFF : cntInc[15:0];

  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    opcode_d     = opcode_q;
    scalar_d     = scalar_q;
    valid_d      = 1'b0;
    status_d     = status_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    pendStatus_d = pendStatus_q;
    pendCycles_d = pendCycles_q;
    faultNext_d  = faultNext_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_opcode_i <= 3'd4) begin
            opcode_d = cmd_opcode_i;
            scalar_d = cmd_scalar_i;
            start_d  = 1'b1;
            cnt_d    = 32'd0;
            state_d  = RUN;
          end else begin
            status_d    = ST_BAD_OP;
            last_d      = 16'd0;
            valid_d     = 1'b1;
            faultNext_d = 1'b0;
            state_d     = REPORT;
          end
        end
      end
      RUN: begin
        cnt_d = cntInc;
        if (alu_error_i || alu_done_i) begin
          pendStatus_d = alu_error_i ? ST_DIM_ERR : ST_OK;
          pendCycles_d = cyclesSat;
          start_d      = 1'b0;
          faultNext_d  = 1'b0;
          state_d      = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          status_d    = ST_TIMEOUT;
          last_d      = cyclesSat;
          valid_d     = 1'b1;
          start_d     = 1'b0;
          faultNext_d = 1'b1;
          state_d     = REPORT;
        end
      end
      RELEASE: begin
        status_d = pendStatus_q;
        last_d   = pendCycles_q;
        valid_d  = 1'b1;
        state_d  = REPORT;
      end
      REPORT:  state_d = faultNext_q ? FAULT : IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      start_q      <= 1'b0;
      opcode_q     <= 3'd0;
      scalar_q     <= 16'd0;
      valid_q      <= 1'b0;
      status_q     <= ST_OK;
      last_q       <= 16'd0;
      cnt_q        <= 32'd0;
      pendStatus_q <= ST_OK;
      pendCycles_q <= 16'd0;
      faultNext_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      opcode_q     <= opcode_d;
      scalar_q     <= scalar_d;
      valid_q      <= valid_d;
      status_q     <= status_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      pendStatus_q <= pendStatus_d;
      pendCycles_q <= pendCycles_d;
      faultNext_q  <= faultNext_d;
    end
  end

  // A pending command always beats the display for the shared read port.
  assign disp_gnt_o      = (state_q == IDLE) && disp_req_i && !cmd_valid_i;
  assign mem_rd_slot_o   = disp_gnt_o ? disp_rd_slot_i : alu_rd_slot_i;
  assign mem_rd_row_o    = disp_gnt_o ? disp_rd_row_i  : alu_rd_row_i;
  assign mem_rd_col_o    = disp_gnt_o ? disp_rd_col_i  : alu_rd_col_i;

  assign cmd_ready_o     = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign alu_start_o     = start_q;
  assign alu_opcode_o    = opcode_q;
  assign alu_scalar_o    = scalar_q;
  assign result_valid_o  = valid_q;
  assign result_status_o = status_q;
  assign last_cycles_o   = last_q;

endmodule

// File: tb/tb_matrix_op_sched.sv
// Directed bench for matrix_op_sched: one instance with the default timeout for
// handshake/arbitration cases, one with TIMEOUT_CYCLES=16 for the watchdog case.
module tb_matrix_op_sched;

  logic        clk = 1'b0;
  logic        rstN;
  logic        cmdValidA, cmdValidB;
  logic [2:0]  cmdOpcode;
  logic [15:0] cmdScalar;
  logic        aluDone, aluError;
  logic        dispReq;
  logic [1:0]  dispSlot, aluSlot;
  logic [2:0]  dispRow, dispCol, aluRow, aluCol;

  logic        cmdReadyA, aluStartA, resultValidA, busyA, dispGntA;
  logic [2:0]  aluOpcodeA, memRowA, memColA;
  logic [15:0] aluScalarA, lastCyclesA;
  logic [1:0]  resultStatusA, memSlotA;

  logic        cmdReadyB, aluStartB, resultValidB, busyB, dispGntB;
  logic [2:0]  aluOpcodeB, memRowB, memColB;
  logic [15:0] aluScalarB, lastCyclesB;
  logic [1:0]  resultStatusB, memSlotB;

  int total = 0;
  int bad = 0;
  int reportCountA = 0;
  int highCount;

  always #5 clk = ~clk;

  matrix_op_sched dutA (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValidA), .cmd_ready_o(cmdReadyA),
    .cmd_opcode_i(cmdOpcode), .cmd_scalar_i(cmdScalar),
    .alu_start_o(aluStartA), .alu_opcode_o(aluOpcodeA), .alu_scalar_o(aluScalarA),
    .alu_done_i(aluDone), .alu_error_i(aluError),
    .result_valid_o(resultValidA), .result_status_o(resultStatusA),
    .last_cycles_o(lastCyclesA), .busy_o(busyA),
    .disp_req_i(dispReq), .disp_gnt_o(dispGntA),
    .disp_rd_slot_i(dispSlot), .disp_rd_row_i(dispRow), .disp_rd_col_i(dispCol),
    .alu_rd_slot_i(aluSlot), .alu_rd_row_i(aluRow), .alu_rd_col_i(aluCol),
    .mem_rd_slot_o(memSlotA), .mem_rd_row_o(memRowA), .mem_rd_col_o(memColA)
  );

  matrix_op_sched #(.TIMEOUT_CYCLES(16)) dutB (
    .clk_i(clk), .rst_ni(rstN),
    .cmd_valid_i(cmdValidB), .cmd_ready_o(cmdReadyB),
    .cmd_opcode_i(cmdOpcode), .cmd_scalar_i(cmdScalar),
    .alu_start_o(aluStartB), .alu_opcode_o(aluOpcodeB), .alu_scalar_o(aluScalarB),
    .alu_done_i(1'b0), .alu_error_i(1'b0),
    .result_valid_o(resultValidB), .result_status_o(resultStatusB),
    .last_cycles_o(lastCyclesB), .busy_o(busyB),
    .disp_req_i(dispReq), .disp_gnt_o(dispGntB),
    .disp_rd_slot_i(dispSlot), .disp_rd_row_i(dispRow), .disp_rd_col_i(dispCol),
    .alu_rd_slot_i(aluSlot), .alu_rd_row_i(aluRow), .alu_rd_col_i(aluCol),
    .mem_rd_slot_o(memSlotB), .mem_rd_row_o(memRowB), .mem_rd_col_o(memColB)
  );

  always @(negedge clk) if (resultValidA === 1'b1) reportCountA <= reportCountA + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] sc, input bit toB);
    cmdOpcode = op;
    cmdScalar = sc;
    if (toB) cmdValidB = 1'b1;
    else     cmdValidA = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rstN = 1'b0; cmdValidA = 1'b0; cmdValidB = 1'b0; cmdOpcode = 3'd0; cmdScalar = 16'd0;
    aluDone = 1'b0; aluError = 1'b0; dispReq = 1'b0;
    dispSlot = 2'd1; dispRow = 3'd2; dispCol = 3'd3;
    aluSlot = 2'd2; aluRow = 3'd5; aluCol = 3'd6;
    repeat (2) @(negedge clk);
    checkOutput("rstStart", aluStartA, 1'b0);
    checkOutput("rstValid", resultValidA, 1'b0);
    checkOutput("rstStatus", resultStatusA, 2'b00);
    checkOutput("rstLast", lastCyclesA, 16'd0);
    checkOutput("rstBusy", busyA, 1'b0);
    rstN = 1'b1;
    #1 checkOutput("rstReady", cmdReadyA, 1'b1);

    // ADD, done after 20 start cycles, with a colliding display request
    applyStimulus(3'd0, 16'h1234, 1'b0);
    dispReq = 1'b1;
    #1 checkOutput("gntCollide", dispGntA, 1'b0);
    @(negedge clk); cmdValidA = 1'b0;
    checkOutput("addStart", {aluStartA, aluOpcodeA, busyA}, {1'b1, 3'd0, 1'b1});
    checkOutput("runGnt", dispGntA, 1'b0);
    checkOutput("runMem", {memSlotA, memRowA, memColA}, {2'd2, 3'd5, 3'd6});
    dispReq = 1'b0;
    for (int n = 2; n <= 19; n++) begin
      @(negedge clk);
      checkOutput("addHold", {aluStartA, aluOpcodeA}, {1'b1, 3'd0});
    end
    @(negedge clk); aluDone = 1'b1;
    checkOutput("addStart20", aluStartA, 1'b1);
    @(negedge clk);
    checkOutput("addDrop", {aluStartA, resultValidA}, 2'b00);
    @(negedge clk); aluDone = 1'b0;
    checkOutput("addReport", {resultValidA, resultStatusA, cmdReadyA}, {1'b1, 2'b00, 1'b0});
    checkOutput("addCycles", lastCyclesA, 16'd20);
    @(negedge clk);
    checkOutput("addIdle", {resultValidA, cmdReadyA, busyA}, {1'b0, 1'b1, 1'b0});
    dispReq = 1'b1;
    #1 checkOutput("dispGnt", dispGntA, 1'b1);
    checkOutput("dispMem", {memSlotA, memRowA, memColA}, {2'd1, 3'd2, 3'd3});
    dispReq = 1'b0;

    // MUL with error and done together on the 5th start cycle
    @(negedge clk); applyStimulus(3'd2, 16'd0, 1'b0);
    @(negedge clk); cmdValidA = 1'b0;
    checkOutput("mulHold", {aluStartA, aluOpcodeA}, {1'b1, 3'd2});
    repeat (3) begin
      @(negedge clk);
      checkOutput("mulHold", {aluStartA, aluOpcodeA}, {1'b1, 3'd2});
    end
    @(negedge clk); aluError = 1'b1; aluDone = 1'b1;
    checkOutput("mulStart5", aluStartA, 1'b1);
    @(negedge clk);
    checkOutput("mulDrop", aluStartA, 1'b0);
    @(negedge clk); aluError = 1'b0; aluDone = 1'b0;
    checkOutput("mulReport", {resultValidA, resultStatusA}, {1'b1, 2'b01});
    checkOutput("mulCycles", lastCyclesA, 16'd5);
    @(negedge clk);
    checkOutput("mulIdle", {resultValidA, cmdReadyA}, {1'b0, 1'b1});
    @(negedge clk);
    checkOutput("mulNoSecond", {resultValidA, resultStatusA}, {1'b0, 2'b01});

    // Illegal opcode
    applyStimulus(3'd6, 16'd7, 1'b0);
    @(negedge clk); cmdValidA = 1'b0;
    checkOutput("badReport", {aluStartA, resultValidA, resultStatusA, cmdReadyA}, {1'b0, 1'b1, 2'b10, 1'b0});
    checkOutput("badCycles", lastCyclesA, 16'd0);
    @(negedge clk);
    checkOutput("badIdle", {cmdReadyA, resultValidA}, {1'b1, 1'b0});

    // SCA then TRA presented while busy, then reset mid-RUN
    applyStimulus(3'd3, 16'd3, 1'b0);
    @(negedge clk); applyStimulus(3'd4, 16'h0055, 1'b0);
    checkOutput("scaHold", {aluStartA, aluOpcodeA, aluScalarA, cmdReadyA}, {1'b1, 3'd3, 16'd3, 1'b0});
    @(negedge clk);
    checkOutput("scaHold", {aluStartA, aluOpcodeA, aluScalarA, cmdReadyA}, {1'b1, 3'd3, 16'd3, 1'b0});
    @(negedge clk); aluDone = 1'b1;
    checkOutput("scaHold", {aluStartA, aluOpcodeA, aluScalarA}, {1'b1, 3'd3, 16'd3});
    @(negedge clk); aluDone = 1'b0;
    checkOutput("scaDrop", {aluStartA, cmdReadyA}, 2'b00);
    @(negedge clk);
    checkOutput("scaReport", {resultValidA, resultStatusA, cmdReadyA}, {1'b1, 2'b00, 1'b0});
    checkOutput("scaCycles", lastCyclesA, 16'd3);
    @(negedge clk);
    checkOutput("traWait", {cmdReadyA, aluStartA}, {1'b1, 1'b0});
    @(negedge clk); cmdValidA = 1'b0;
    checkOutput("traStart", {aluStartA, aluOpcodeA, aluScalarA}, {1'b1, 3'd4, 16'h0055});
    @(negedge clk);
    checkOutput("reportCount", reportCountA, 4);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("midRst", {aluStartA, busyA, cmdReadyA, resultValidA}, 4'b0010);
    checkOutput("midRstRegs", {aluOpcodeA, aluScalarA, lastCyclesA, resultStatusA}, 37'd0);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("postRst", {aluStartA, reportCountA[7:0]}, {1'b0, 8'd4});

    // Timeout instance: ALU never finishes
    applyStimulus(3'd1, 16'd0, 1'b1);
    @(negedge clk); cmdValidB = 1'b0;
    checkOutput("toOpcode", aluOpcodeB, 3'd1);
    highCount = 0;
    for (int n = 1; n <= 16; n++) begin
      if (n > 1) @(negedge clk);
      if (aluStartB === 1'b1) highCount++;
    end
    @(negedge clk);
    checkOutput("toHighCycles", highCount, 16);
    checkOutput("toReport", {aluStartB, resultValidB, resultStatusB}, {1'b0, 1'b1, 2'b11});
    checkOutput("toCycles", lastCyclesB, 16'd16);
    @(negedge clk);
    checkOutput("fault", {resultValidB, cmdReadyB, busyB, aluStartB}, 4'b0010);
    dispReq = 1'b1;
    applyStimulus(3'd0, 16'd0, 1'b1);
    #1 checkOutput("faultGnt", dispGntB, 1'b0);
    @(negedge clk);
    checkOutput("faultStuck", {aluStartB, cmdReadyB}, 2'b00);
    cmdValidB = 1'b0; dispReq = 1'b0; rstN = 1'b0;
    @(negedge clk); rstN = 1'b1;
    #1 checkOutput("faultRst", {cmdReadyB, busyB, resultValidB, resultStatusB}, {1'b1, 1'b0, 1'b0, 2'b00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/matrix_op_sched.md
# matrix_op_sched

Command scheduler and read-port arbiter in front of `matrix_alu`. It accepts one matrix command at a time from the front end (UI/UART decoder) and validates the opcode. It runs the ALU's hold-start/done/error handshake, bounds each operation with a timeout, and reports a status code. When the ALU is idle, it also lends the matrix-memory read port to a display/readout requester.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum cycles `alu_start` stays high before a timeout is declared. Must be ≥ 2.
- `clk` input 1: single clock; all logic on rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `cmd_valid` input 1: front end presents a command.
- `cmd_ready` output 1: high only in IDLE; a command is accepted when `cmd_valid && cmd_ready`.
- `cmd_opcode` input 3: 0 ADD, 1 SUB, 2 MUL, 3 SCA, 4 TRA.
- `cmd_scalar` input 16: scalar operand, used by SCA.
- `alu_start` output 1: held high for the whole operation.
- `alu_opcode` output 3: latched opcode, stable while `alu_start` is high.
- `alu_scalar` output 16: latched scalar, stable while `alu_start` is high.
- `alu_done` input 1: ALU completion, re-asserted every cycle while the ALU waits in DONE.
- `alu_error` input 1: ALU dimension-check failure.
- `result_valid` output 1: one-cycle pulse reporting the outcome of a command.
- `result_status` output 2: 00 OK, 01 DIM_ERR, 10 BAD_OP, 11 TIMEOUT. Held until the next report.
- `last_cycles` output 16: number of cycles `alu_start` was high for the last command. Saturates at 0xFFFF; 0 for BAD_OP.
- `busy` output 1: high in every state except IDLE.
- `disp_req` input 1: display reader requests the memory read port.
- `disp_gnt` output 1: display owns the read port this cycle (combinational).
- `disp_rd_slot` input 2, `disp_rd_row` input 3, `disp_rd_col` input 3: display read address.
- `alu_rd_slot` input 2, `alu_rd_row` input 3, `alu_rd_col` input 3: ALU read address.
- `mem_rd_slot` output 2, `mem_rd_row` output 3, `mem_rd_col` output 3: muxed address to `matrix_mem`.

## Operation
- States: IDLE, RUN, RELEASE, REPORT, FAULT.
- IDLE behaviour:
  - `cmd_ready`=1.
  - On accept with `cmd_opcode` ≤ 4: latch opcode and scalar, set `alu_start`<=1, clear the cycle counter, go to RUN.
  - On accept with `cmd_opcode` ≥ 5: the ALU is not started; set `result_status`<=10, go to REPORT.
- RUN: cycle counter increments each cycle. Exits are checked in priority order:
  1. `alu_error`=1: status 01, `alu_start`<=0, go to RELEASE.
  2. Else `alu_done`=1: status 00, `alu_start`<=0, go to RELEASE.
  3. Else the counter reaches `TIMEOUT_CYCLES`-1: status 11, `alu_start`<=0, go to REPORT with FAULT as the next state.
- RELEASE: one cycle with `alu_start`=0 so the ALU leaves DONE/ERROR and returns to its IDLE. Then go to REPORT.
- REPORT:
  - `result_valid`=1 for exactly this cycle.
  - `last_cycles` is updated.
  - Next state is IDLE, or FAULT after a timeout.
- FAULT: terminal. `cmd_ready`=0, `busy`=1, `alu_start`=0, `disp_gnt`=0. Left only by `rst_n`=0.
- Arbitration:
  - `disp_gnt` = state==IDLE && `disp_req` && !(`cmd_valid`). A command always wins a simultaneous request.
  - While `disp_gnt`=1, `mem_rd_*` = `disp_rd_*`; otherwise `mem_rd_*` = `alu_rd_*`.
  - Read data is shared, so no data mux is needed.
- `cmd_opcode` and `cmd_scalar` are ignored outside IDLE. Commands arriving while busy are not queued.

## Timing
- Reset values: state IDLE, `alu_start`=0, `alu_opcode`=0, `alu_scalar`=0, `result_valid`=0, `result_status`=00, `last_cycles`=0, cycle counter 0.
- Combinational outputs in reset: `busy`=0 and `cmd_ready`=1 once `rst_n` is high.
- Accept at edge T: `alu_start` is high from T+1.
- First `alu_done`=1 sampled at edge D: `alu_start`=0 from D+1, `result_valid` high in cycle D+2, `cmd_ready` high again from D+3.
- `last_cycles` = D − T, meaning the number of cycles `alu_start` was high before the drop.
- BAD_OP accepted at T: `result_valid` in cycle T+1, IDLE at T+2.
- Timeout: `alu_start` drops after `TIMEOUT_CYCLES` high cycles, followed by `result_valid` and then FAULT.
- Minimum spacing between accepted commands is 4 cycles plus the ALU run time.
- `alu_opcode` and `alu_scalar` do not change while `alu_start`=1.
- Reset mid-operation (`rst_n`=0 at any edge): all registers return to reset values at that edge and `alu_start` drops. The ALU shares `rst_n`.
- `alu_done`/`alu_error` sampled outside RUN are ignored.

## Test plan
- ADD of 2×2 matrices (ALU model reports done after 20 cycles of start) -> `alu_opcode`=0 held; `alu_start` drops one cycle after done; `result_valid` pulse with status 00; `last_cycles`=20.
- MUL with `alu_error` asserted on the 5th start cycle, `alu_done` also high that cycle -> status 01; `alu_start` low the next cycle; no second report.
- `cmd_opcode`=6 -> `alu_start` never rises; `result_valid` on the next cycle with status 10, `last_cycles`=0; `cmd_ready` high two cycles after the accept.
- `TIMEOUT_CYCLES`=16, ALU model never completes -> `alu_start` high for exactly 16 cycles; status 11; FAULT with `cmd_ready`=0. A subsequent `rst_n` pulse restores IDLE.
- `disp_req` and `cmd_valid` asserted in the same IDLE cycle -> `disp_gnt`=0, command accepted. `disp_req` alone in IDLE with display address (1,2,3) -> `disp_gnt`=1, `mem_rd_*`=(1,2,3). `disp_req` during RUN -> `disp_gnt`=0, `mem_rd_*` follows `alu_rd_*`.
- Back-to-back: SCA with scalar 3, followed by TRA presented while busy -> TRA waits for `cmd_ready`; each command gets exactly one report; `rst_n`=0 mid-RUN drops `alu_start` and returns to IDLE at that edge.
